// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory request/grant/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : IF stage - PC, single-outstanding word fetch, skid-buffered
//               IF/ID producer with stall and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    if_fetch_unit_if.master  imem,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst
);

    localparam logic [1:0] c_st_req   = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic        w_out_free;

    assign w_out_free = !if_valid || !stall;
    assign imem.req   = (r_state == c_st_req) && !rst;
    assign imem.addr  = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_req;
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_INST;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_inst     <= NOP_INST;
        end else if (redirect_valid) begin
            // Any in-flight response must still be swallowed before refetching.
            r_pc     <= {redirect_pc[31:2], 2'b00};
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
            case (r_state)
                c_st_req:   r_state <= imem.gnt ? c_st_drain : c_st_req;
                c_st_wait,
                c_st_drain: r_state <= imem.rvalid ? c_st_req : c_st_drain;
                default:    r_state <= c_st_req;
            endcase
        end else begin
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
                if_inst  <= NOP_INST;
            end
            case (r_state)
                c_st_req: begin
                    if (imem.gnt) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (imem.rvalid) begin
                        if (w_out_free) begin
                            if_valid <= 1'b1;
                            if_pc    <= r_req_pc;
                            if_inst  <= imem.rdata;
                            r_state  <= c_st_req;
                        end else begin
                            r_skid_pc   <= r_req_pc;
                            r_skid_inst <= imem.rdata;
                            r_state     <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    if (!stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= r_skid_pc;
                        if_inst  <= r_skid_inst;
                        r_state  <= c_st_req;
                    end
                end
                default: begin
                    if (imem.rvalid) begin
                        r_state <= c_st_req;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Scoreboard bench for if_fetch_unit with a random memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam logic [31:0] c_key      = 32'hA5A5_A5A5;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(
        .RESET_PC (c_reset_pc),
        .NOP_INST (c_nop)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_consumed = 0;

    // Program-order stream expected at the IF/ID boundary.
    logic [31:0] exp_q[$];

    // Memory model state.
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          gnt_mode = 0;     // 0: always, 1: random, 2: never
    bit          lat_rand = 0;
    int          lat_fixed = 1;
    bit          keep_stale = 0;

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic restart_stream(input logic [31:0] target);
        logic [31:0] p;
        exp_q.delete();
        p = {target[31:2], 2'b00};
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        restart_stream(c_reset_pc);
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!if_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid_timeout", 64'(if_valid), 64'd1);
    endtask

    // Memory response driver: responses come lat cycles after the grant.
    initial begin
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       imem_bus.gnt = 1'b1;
                1:       imem_bus.gnt = 1'($urandom_range(0, 1));
                default: imem_bus.gnt = 1'b0;
            endcase
            if (pend && pend_cnt == 0) begin
                imem_bus.rvalid = 1'b1;
                imem_bus.rdata  = pend_addr ^ c_key;
                pend = 0;
            end else begin
                imem_bus.rvalid = 1'b0;
                imem_bus.rdata  = $urandom;
                if (pend) pend_cnt--;
            end
        end
    end

    // Memory grant bookkeeping and protocol check.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (!keep_stale) pend = 0;
        end else if (imem_bus.req && imem_bus.gnt) begin
            check("one_outstanding", 64'(pend), 64'd0);
            check("addr_aligned", 64'(imem_bus.addr[1:0]), 64'd0);
            pend      = 1;
            pend_addr = imem_bus.addr;
            pend_cnt  = (lat_rand ? int'($urandom_range(1, 3)) : lat_fixed) - 1;
        end
    end

    // Scoreboard monitor: every consumed instruction is the next in program order.
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (!rst && !redirect_valid && if_valid && !stall) begin
            n_consumed++;
            check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc_inst", {if_pc, if_inst}, {e, e ^ c_key});
            end
        end
    end

    initial begin
        logic [31:0] t;
        int base;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        restart_stream(c_reset_pc);

        // Reset state
        cyc();
        @(negedge clk);
        check("rst_req_low", 64'(imem_bus.req), 64'd0);
        cyc();
        @(negedge clk);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_pc", 64'(if_pc), 64'd0);
        check("rst_if_inst", 64'(if_inst), 64'(c_nop));
        check("rst_req_low2", 64'(imem_bus.req), 64'd0);

        // Sequential fetch
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            check("seq_valid", 64'(if_valid), 64'(i >= 2 && i % 2 == 0));
            check("seq_req", 64'(imem_bus.req), 64'(i % 2 == 0));
            if (i % 2 == 0) check("seq_addr", 64'(imem_bus.addr), 64'(4 * (i / 2)));
        end

        // Stall with skid
        do_reset();
        cycles(4);
        stall = 1'b1;
        cycles(2);
        @(negedge clk);
        check("skid_valid_held", 64'(if_valid), 64'd1);
        check("skid_pc_held", 64'(if_pc), 64'h4);
        check("skid_hold_noreq", 64'(imem_bus.req), 64'd0);
        cyc();
        stall = 1'b0;
        @(negedge clk);
        check("skid_release_noreq", 64'(imem_bus.req), 64'd0);
        check("skid_release_pc", 64'(if_pc), 64'h4);
        cyc();
        @(negedge clk);
        check("skid_out_pc", 64'(if_pc), 64'h8);
        check("skid_next_addr", {63'd0, imem_bus.req, 32'd0} | 64'(imem_bus.addr), {63'd1, 32'd0} | 64'hC);

        // Redirect during WAIT
        do_reset();
        cycles(5);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        restart_stream(redirect_pc);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rdw_valid", 64'(if_valid), 64'd0);
        check("rdw_inst", 64'(if_inst), 64'(c_nop));
        check("rdw_req", 64'(imem_bus.req), 64'd1);
        check("rdw_addr", 64'(imem_bus.addr), 64'h100);
        wait_valid(12);
        check("rdw_out", {if_pc, if_inst}, {32'h100, 32'h100 ^ c_key});

        // Redirect on a granted REQ, then gnt low
        cycles(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        restart_stream(redirect_pc);
        @(negedge clk);
        check("rgr_granted", 64'(imem_bus.req && imem_bus.gnt), 64'd1);
        cyc();
        redirect_valid = 1'b0;
        gnt_mode = 2;
        @(negedge clk);
        check("rgr_drain_noreq", 64'(imem_bus.req), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("rgr_req_hold", 64'(imem_bus.req), 64'd1);
            check("rgr_addr_hold", 64'(imem_bus.addr), 64'h200);
        end
        cyc();
        gnt_mode = 0;
        stall = 1'b1;
        wait_valid(12);
        check("rgr_out_pc", 64'(if_pc), 64'h200);

        // Redirect while stalled with the skid full
        cycles(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        restart_stream(redirect_pc);
        lat_fixed = 2;
        @(negedge clk);
        check("rsk_hold_noreq", 64'(imem_bus.req), 64'd0);
        check("rsk_hold_pc", {if_valid, if_pc}, {1'b1, 32'h200});
        cyc();
        redirect_valid = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("rsk_valid", 64'(if_valid), 64'd0);
        check("rsk_inst", 64'(if_inst), 64'(c_nop));
        check("rsk_req", 64'(imem_bus.req), 64'd1);
        check("rsk_addr", 64'(imem_bus.addr), 64'h300);
        wait_valid(12);
        check("rsk_out_pc", 64'(if_pc), 64'h300);

        // Synchronous reset in WAIT with a stale response after release
        cyc();
        rst = 1'b1;
        keep_stale = 1'b1;
        restart_stream(c_reset_pc);
        @(negedge clk);
        check("rwt_req_low", 64'(imem_bus.req), 64'd0);
        cyc();
        rst = 1'b0;
        keep_stale = 1'b0;
        @(negedge clk);
        check("rwt_valid", 64'(if_valid), 64'd0);
        check("rwt_pc", 64'(if_pc), 64'd0);
        check("rwt_inst", 64'(if_inst), 64'(c_nop));
        check("rwt_req", 64'(imem_bus.req), 64'd1);
        check("rwt_addr", 64'(imem_bus.addr), 64'(c_reset_pc));
        wait_valid(12);
        check("rwt_out", {if_pc, if_inst}, {c_reset_pc, c_reset_pc ^ c_key});

        // Randomized traffic
        gnt_mode = 1;
        lat_rand = 1;
        base = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) < 4) begin
                t = $urandom;
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | {28'd0, t[3:0]};
                redirect_valid = 1'b1;
                redirect_pc = t;
                restart_stream(t);
            end else begin
                redirect_valid = 1'b0;
            end
            rst = ($urandom_range(0, 499) == 0);
            if (rst) restart_stream(c_reset_pc);
        end
        cyc();
        rst = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        check("rand_progress", 64'(n_consumed - base > 150), 64'd1);
        cycles(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
